// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the hardwired control unit.
// It defines the opcode values (IR[31:27]), the sequencer state encoding
// and the instruction-class encoding. The constants are plain localparams
// so that older tools that do not accept typedef enums can read them.
package cpu_ctrl_pkg;

    // Opcodes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // Sequencer states
    localparam logic [3:0] ST_T0     = 4'd0;
    localparam logic [3:0] ST_T1     = 4'd1;
    localparam logic [3:0] ST_T2     = 4'd2;
    localparam logic [3:0] ST_T3     = 4'd3;
    localparam logic [3:0] ST_T4     = 4'd4;
    localparam logic [3:0] ST_T5     = 4'd5;
    localparam logic [3:0] ST_T6     = 4'd6;
    localparam logic [3:0] ST_HALTED = 4'd7;
    localparam logic [3:0] ST_FAULT  = 4'd8;

    // Instruction classes
    localparam logic [2:0] CL_ALU3 = 3'd0;
    localparam logic [2:0] CL_IMM  = 3'd1;
    localparam logic [2:0] CL_MD   = 3'd2;
    localparam logic [2:0] CL_UN   = 3'd3;
    localparam logic [2:0] CL_MF   = 3'd4;
    localparam logic [2:0] CL_NOP  = 3'd5;
    localparam logic [2:0] CL_HALT = 3'd6;
    localparam logic [2:0] CL_ILL  = 3'd7;

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier.
// Ports:
//   i_opcode  in   OPC_W  instruction opcode (IR[31:27])
//   o_class   out  3      instruction class (CL_* in cpu_ctrl_pkg)
//   o_illegal out  1      opcode is not supported
module instr_class_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W = 5
) (
    input  logic [OPC_W-1:0] i_opcode,
    output logic [2:0]       o_class,
    output logic             o_illegal
);

    always_comb begin
        o_class   = CL_ILL;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:   o_class = CL_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:          o_class = CL_IMM;
            OP_MUL, OP_DIV:                    o_class = CL_MD;
            OP_NEG, OP_NOT:                    o_class = CL_UN;
            OP_MFHI, OP_MFLO:                  o_class = CL_MF;
            OP_NOP:                            o_class = CL_NOP;
            OP_HALT:                           o_class = CL_HALT;
            default: begin
                o_class   = CL_ILL;
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute control unit for the single-bus 32-bit
// datapath. A Moore machine: every strobe is decoded from the registered
// state and the opcode latched from IR; the only input gating an output is
// run, which enables the fetch strobes in T0.
// Ports:
//   clk        in   rising-edge clock
//   clr        in   synchronous active-low reset
//   run        in   fetch enable, sampled only in T0
//   ir         in   instruction register contents, opcode = ir[31:27]
//   mem_ready  in   memory read data valid
//   PCout..IRin              out  fetch-path strobes
//   Gra/Grb/Grc/Rin/Rout     out  register select and direction
//   Yin..Cout                out  ALU / special-register strobes
//   operation  out  ALU opcode, non-zero only in the Z-load cycle
//   halted     out  sequencer stopped (halt opcode or memory timeout)
//   illegal_op out  one-cycle pulse on an unsupported opcode
//   mem_fault  out  sticky memory-read timeout flag
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPC_W       = 5,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic [31:0] ir,
    input  logic       mem_ready,
    output logic       PCout,
    output logic       IncPC,
    output logic       MARin,
    output logic       Read,
    output logic       MDRin,
    output logic       MDRout,
    output logic       IRin,
    output logic       Gra,
    output logic       Grb,
    output logic       Grc,
    output logic       Rin,
    output logic       Rout,
    output logic       Yin,
    output logic       ZHighIn,
    output logic       ZLowIn,
    output logic       ZHighout,
    output logic       ZLowout,
    output logic       HIin,
    output logic       LOin,
    output logic       HIout,
    output logic       LOout,
    output logic       Cout,
    output logic [4:0] operation,
    output logic       halted,
    output logic       illegal_op,
    output logic       mem_fault
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_mem_fault;
    logic [OPC_W-1:0] r_op;
    logic [OPC_W-1:0] w_op;
    logic [2:0]       w_class;
    logic             w_illegal;
    logic             w_unused_ir;

    // IR only holds the new instruction from T3 onward, so T3 decodes the
    // live ir and later cycles use the copy taken at the end of T3.
    assign w_op        = (r_state == ST_T3) ? ir[31 -: OPC_W] : r_op;
    // Operand fields are consumed by the datapath, not by this unit.
    assign w_unused_ir = ^ir[31-OPC_W:0];

    instr_class_decode #(.OPC_W(OPC_W)) u_decode (
        .i_opcode  (w_op),
        .o_class   (w_class),
        .o_illegal (w_illegal)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_T0: if (run) w_next = ST_T1;
            ST_T1: begin
                if (mem_ready)
                    w_next = ST_T2;
                else if (r_cnt == CNT_W'(MEM_TIMEOUT - 1))
                    w_next = ST_FAULT;
            end
            ST_T2: w_next = ST_T3;
            ST_T3: begin
                case (w_class)
                    CL_MF, CL_NOP, CL_ILL: w_next = ST_T0;
                    CL_HALT:               w_next = ST_HALTED;
                    default:               w_next = ST_T4;
                endcase
            end
            ST_T4: w_next = (w_class == CL_UN) ? ST_T0 : ST_T5;
            ST_T5: w_next = (w_class == CL_MD) ? ST_T6 : ST_T0;
            ST_T6: w_next = ST_T0;
            ST_HALTED, ST_FAULT: w_next = r_state;
            default: w_next = ST_T0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state     <= ST_T0;
            r_cnt       <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            // Counts consecutive T1 cycles without mem_ready.
            if (r_state == ST_T1 && !mem_ready)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if (w_next == ST_FAULT)
                r_mem_fault <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == ST_T3)
            r_op <= ir[31 -: OPC_W];
    end

    always_comb begin
        PCout = 1'b0; IncPC = 1'b0; MARin = 1'b0; Read = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0;
        Yin = 1'b0; ZHighIn = 1'b0; ZLowIn = 1'b0; ZHighout = 1'b0;
        ZLowout = 1'b0; HIin = 1'b0; LOin = 1'b0; HIout = 1'b0;
        LOout = 1'b0; Cout = 1'b0;
        operation  = '0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        case (r_state)
            ST_T0: begin
                PCout = run; MARin = run; IncPC = run;
            end
            ST_T1: begin
                Read = 1'b1; MDRin = 1'b1;
            end
            ST_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            ST_T3: begin
                case (w_class)
                    CL_ALU3, CL_IMM: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    CL_MD: begin
                        Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    CL_UN: begin
                        Grb = 1'b1; Rout = 1'b1;
                        ZHighIn = 1'b1; ZLowIn = 1'b1; operation = w_op;
                    end
                    CL_MF: begin
                        HIout = (w_op == OP_MFHI);
                        LOout = (w_op != OP_MFHI);
                        Gra = 1'b1; Rin = 1'b1;
                    end
                    CL_ILL: illegal_op = w_illegal;
                    default: ;
                endcase
            end
            ST_T4: begin
                case (w_class)
                    CL_ALU3: begin
                        Grc = 1'b1; Rout = 1'b1;
                        ZHighIn = 1'b1; ZLowIn = 1'b1; operation = w_op;
                    end
                    CL_IMM: begin
                        Cout = 1'b1;
                        ZHighIn = 1'b1; ZLowIn = 1'b1; operation = w_op;
                    end
                    CL_MD: begin
                        Grb = 1'b1; Rout = 1'b1;
                        ZHighIn = 1'b1; ZLowIn = 1'b1; operation = w_op;
                    end
                    CL_UN: begin
                        ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                ZLowout = 1'b1;
                if (w_class == CL_MD) begin
                    LOin = 1'b1;
                end else begin
                    Gra = 1'b1; Rin = 1'b1;
                end
            end
            ST_T6: begin
                ZHighout = 1'b1; HIin = 1'b1;
            end
            ST_HALTED, ST_FAULT: halted = 1'b1;
            default: ;
        endcase
    end

    assign mem_fault = r_mem_fault;

    // The single bus allows at most one driver per cycle.
    a_one_bus_out: assert property (@(posedge clk) disable iff (!clr)
        $onehot0({PCout, MDRout, Rout, ZHighout, ZLowout, HIout, LOout, Cout}));

endmodule
